// File: rtl/id_ctrl_pkg.sv
// Shared definitions for the ID-stage control decoder: opcode/funct codes,
// control-bundle bit layout and stage FSM states.
package id_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;
  localparam logic [5:0] OP_EXW    = 6'h3f;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_ALU_LO = 6'h20;
  localparam logic [5:0] FN_ALU_HI = 6'h2b;

  // Control bundle layout, LSB first; bit 18 is reserved and always zero.
  localparam int CTRL_W          = 19;
  localparam int CTRL_LU_OP      = 0;
  localparam int CTRL_EXT_OP     = 1;
  localparam int CTRL_ALU_SRC1   = 2;
  localparam int CTRL_ALU_SRC2   = 3;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_EX_ANO     = 6;
  localparam int CTRL_EX_WRITE   = 8;
  localparam int CTRL_MEM_WRITE  = 9;
  localparam int CTRL_BYTE_READ  = 10;
  localparam int CTRL_MEM_READ   = 11;
  localparam int CTRL_REG_DST    = 12;
  localparam int CTRL_REG_WRITE  = 14;
  localparam int CTRL_BRANCH     = 15;
  localparam int CTRL_PC_SRC     = 16;
  localparam int CTRL_RSVD       = 18;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_LU  = 2'd1,
    ST_EXW = 2'd2
  } state_t;

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn inside {FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR}) ||
                     ((fn >= FN_ALU_LO) && (fn <= FN_ALU_HI));
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_LUI,
      OP_LB, OP_LW, OP_SW, OP_EXW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_ctrl_stage_decode.sv
// Combinational opcode/funct to control-bundle table; usable outside the
// pipeline stage.
module ctrl_decode
  import id_ctrl_pkg::*;
(
  input  logic [5:0]        i_opcode,
  input  logic [5:0]        i_funct,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic w_rtype;
  logic w_branch;
  logic w_jump;
  logic w_jr;
  logic w_jalr;
  logic w_link;
  logic w_load;
  logic w_imm;

  always_comb begin
    w_rtype  = (i_opcode == OP_RTYPE);
    w_branch = i_opcode inside {OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
    w_jump   = i_opcode inside {OP_J, OP_JAL};
    w_jr     = w_rtype && (i_funct == FN_JR);
    w_jalr   = w_rtype && (i_funct == FN_JALR);
    w_link   = (i_opcode == OP_JAL) || w_jalr;
    w_load   = i_opcode inside {OP_LW, OP_LB};
    // Ops whose second ALU operand is the immediate and whose destination is rt.
    w_imm    = i_opcode inside {OP_LW, OP_LB, OP_SW, OP_LUI, OP_ADDI, OP_ADDIU,
                                OP_SLTI, OP_SLTIU, OP_ANDI};

    o_ctrl = '0;
    o_ctrl[CTRL_PC_SRC +: 2]     = w_branch       ? 2'b01 :
                                   w_jump         ? 2'b10 :
                                   (w_jr | w_jalr) ? 2'b11 : 2'b00;
    o_ctrl[CTRL_BRANCH]          = w_branch;
    o_ctrl[CTRL_REG_WRITE]       = !(w_branch || (i_opcode == OP_J) || (i_opcode == OP_EXW) ||
                                     (i_opcode == OP_SW) || w_jr || w_jalr);
    o_ctrl[CTRL_REG_DST +: 2]    = w_link ? 2'b10 : (w_imm ? 2'b01 : 2'b00);
    o_ctrl[CTRL_MEM_READ]        = (i_opcode == OP_LW);
    o_ctrl[CTRL_BYTE_READ]       = (i_opcode == OP_LB);
    o_ctrl[CTRL_MEM_WRITE]       = (i_opcode == OP_SW);
    o_ctrl[CTRL_EX_WRITE]        = (i_opcode == OP_EXW);
    o_ctrl[CTRL_EX_ANO +: 2]     = i_funct[1:0];
    o_ctrl[CTRL_MEM_TO_REG +: 2] = w_load ? 2'b01 : (w_link ? 2'b10 : 2'b00);
    o_ctrl[CTRL_ALU_SRC2]        = w_imm;
    o_ctrl[CTRL_ALU_SRC1]        = w_rtype && (i_funct inside {FN_SLL, FN_SRL, FN_SRA});
    o_ctrl[CTRL_EXT_OP]          = (i_opcode == OP_ANDI);
    o_ctrl[CTRL_LU_OP]           = (i_opcode == OP_LUI);
    o_ctrl[CTRL_RSVD]            = 1'b0;
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID stage: decodes into the ID/EX control register, inserts load-use and
// external-write bubbles. CTRL_ILLEGAL_TRAP_EN adds the illegal_op trap.
module id_ctrl_stage
  import id_ctrl_pkg::*;
#(
  parameter int RA_W       = 5,
  parameter int LU_BUBBLES = 1,
  parameter int EXW_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  input  logic              ex_load,
  input  logic [RA_W-1:0]   ex_rt,
  input  logic              flush,
  output logic              stall_if,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic              illegal_op
`endif
);

  localparam logic [3:0] LU_INIT  = 4'(LU_BUBBLES - 1);
  localparam logic [3:0] EXW_INIT = 4'((EXW_CYCLES > 0) ? EXW_CYCLES - 1 : 0);

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_cnt;
  logic [3:0]        w_next_cnt;
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CTRL_W-1:0] w_dec_ctrl;
  logic              w_hz;
  logic              w_stall;
  logic              w_load_valid;
  logic [CTRL_W-1:0] w_load_ctrl;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic              r_illegal;
  logic              w_illegal;
`endif

  ctrl_decode u_decode (
    .i_opcode (opcode),
    .i_funct  (funct),
    .o_ctrl   (w_dec_ctrl)
  );

  assign w_hz = in_valid && ex_load && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));

  // Anything not explicitly loaded below becomes a bubble (all-zero bundle).
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_stall      = 1'b0;
    w_load_valid = 1'b0;
    w_load_ctrl  = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_illegal    = 1'b0;
`endif
    if (flush) begin
      w_next_state = ST_RUN;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hz) begin
            w_stall = 1'b1;
            if (LU_BUBBLES > 1) begin
              w_next_state = ST_LU;
              w_next_cnt   = LU_INIT;
            end
          end else if (in_valid) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (!is_supported(opcode, funct)) begin
              w_illegal = 1'b1;
            end else
`endif
            begin
              w_load_valid = 1'b1;
              w_load_ctrl  = w_dec_ctrl;
              if (w_dec_ctrl[CTRL_EX_WRITE] && (EXW_CYCLES > 0)) begin
                w_next_state = ST_EXW;
                w_next_cnt   = EXW_INIT;
              end
            end
          end
        end
        // The hazard cycle in RUN is the first bubble, so LU covers the rest.
        ST_LU: begin
          w_stall    = 1'b1;
          w_next_cnt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_next_state = ST_RUN;
            w_next_cnt   = '0;
          end
        end
        // The issuing cycle does not stall, so EXW holds for the full count.
        ST_EXW: begin
          w_stall = 1'b1;
          if (r_cnt == '0) begin
            w_next_state = ST_RUN;
          end else begin
            w_next_cnt = r_cnt - 4'd1;
          end
        end
        default: begin
          w_next_state = ST_RUN;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_ctrl  <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_valid <= w_load_valid;
      r_ctrl  <= w_load_ctrl;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r_illegal <= w_illegal;
`endif
    end
  end

  assign stall_if  = w_stall && !reset;
  assign out_valid = r_valid;
  assign out_ctrl  = r_ctrl;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_op = r_illegal;
`endif

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: directed scenarios plus random traffic
// against a cycle-level reference model of decode and stall behaviour.
module tb_id_ctrl_stage;
  import id_ctrl_pkg::*;

  localparam int LU_B  = 2;
  localparam int EXW_C = 3;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, in_valid, ex_load, flush;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, ex_rt;
  logic              stall_if, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic              obs_ill;

  id_ctrl_stage #(.RA_W(5), .LU_BUBBLES(LU_B), .EXW_CYCLES(EXW_C)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .ex_load(ex_load), .ex_rt(ex_rt), .flush(flush),
    .stall_if(stall_if), .out_valid(out_valid), .out_ctrl(out_ctrl)
`ifdef CTRL_ILLEGAL_TRAP_EN
    , .illegal_op(obs_ill)
`endif
  );
`ifndef CTRL_ILLEGAL_TRAP_EN
  assign obs_ill = 1'b0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_hold = 0;                       // stall cycles still owed by the model
  logic [CTRL_W+1:0] exp_q[$];          // {illegal, valid, ctrl} for the next edge
  logic [CTRL_W+2:0] obs_vec, exp_vec;  // {stall, valid, ctrl, illegal}

  // Per-instruction truth table for the control bundle.
  function automatic logic [CTRL_W-1:0] m_decode(input logic [5:0] op, input logic [5:0] fn);
    logic [1:0] pc, dst, m2r;
    logic br, rw, mr, rb, mw, xw, a2, a1, ext, lu;
    pc = 2'd0; dst = 2'd0; m2r = 2'd0; br = 0; rw = 1; mr = 0; rb = 0; mw = 0;
    xw = 0; a2 = 0; a1 = 0; ext = 0; lu = 0;
    case (op)
      6'h00: case (fn)
               6'h08: begin pc = 2'd3; rw = 0; end
               6'h09: begin pc = 2'd3; rw = 0; dst = 2'd2; m2r = 2'd2; end
               6'h00, 6'h02, 6'h03: a1 = 1;
               default: ;
             endcase
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07: begin pc = 2'd1; br = 1; rw = 0; end
      6'h02: begin pc = 2'd2; rw = 0; end
      6'h03: begin pc = 2'd2; dst = 2'd2; m2r = 2'd2; end
      6'h08, 6'h09, 6'h0a, 6'h0b: begin dst = 2'd1; a2 = 1; end
      6'h0c: begin dst = 2'd1; a2 = 1; ext = 1; end
      6'h0f: begin dst = 2'd1; a2 = 1; lu = 1; end
      6'h20: begin dst = 2'd1; a2 = 1; rb = 1; m2r = 2'd1; end
      6'h23: begin dst = 2'd1; a2 = 1; mr = 1; m2r = 2'd1; end
      6'h2b: begin dst = 2'd1; a2 = 1; mw = 1; rw = 0; end
      6'h3f: begin xw = 1; rw = 0; end
      default: ;
    endcase
    return {1'b0, pc, br, rw, dst, mr, rb, mw, xw, fn[1:0], m2r, a2, a1, ext, lu};
  endfunction

  function automatic logic m_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 || fn == 6'h08 || fn == 6'h09 ||
              (fn >= 6'h20 && fn <= 6'h2b));
    return (op <= 6'h0c || op == 6'h0f || op == 6'h20 || op == 6'h23 || op == 6'h2b || op == 6'h3f);
  endfunction

  // One clock: model predicts this cycle's stall and next-edge outputs, then samples DUT.
  task automatic tick();
    logic hz, ill, v, m_stall, o_stall;
    logic [CTRL_W-1:0] c;
    logic [CTRL_W+1:0] e;
    #1;
    hz = in_valid && ex_load && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
    ill = 0; v = 0; c = '0; m_stall = 0;
    if (reset || flush) m_hold = 0;
    else if (m_hold > 0) begin m_stall = 1; m_hold--; end
    else if (hz) begin m_stall = 1; m_hold = LU_B - 1; end
    else if (in_valid) begin
      if (TRAP && !m_legal(opcode, funct)) ill = 1;
      else begin
        v = 1;
        c = m_decode(opcode, funct);
        if (opcode == 6'h3f) m_hold = EXW_C;
      end
    end
    o_stall = stall_if;
    exp_q.push_back({ill, v, c});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    exp_vec = {m_stall, e[CTRL_W], e[CTRL_W-1:0], e[CTRL_W+1]};
    obs_vec = {o_stall, out_valid, out_ctrl, obs_ill};
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] s,
                           input logic [4:0] t);
    in_valid = 1; opcode = op; funct = fn; rs = s; rt = t;
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      set_instr(6'h23, 6'($urandom), 5'd4, 5'd4);
      ex_load = 1; ex_rt = 5'd4; flush = 0;
      tick();
      checks++;
      if (obs_vec !== exp_vec || out_valid !== 1'b0 || out_ctrl !== '0) begin
        errors++; $display("FAIL reset cyc%0d: got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    reset = 0; ex_load = 0; in_valid = 0;
  endtask

  task automatic test_load_use();
    set_instr(6'h00, 6'h20, 5'd8, 5'd9);
    ex_load = 1; ex_rt = 5'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      ex_load = 0;
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL load_use cyc%0d: got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_ctrl[14] !== 1'b1 || out_ctrl[13:12] !== 2'b00) begin
      errors++; $display("FAIL load_use_issue: got v=%b ctrl=%h exp v=1 rw=1 dst=00",
                         out_valid, out_ctrl);
    end
    in_valid = 0;
  endtask

  task automatic test_zero_reg();
    set_instr(6'h00, 6'h21, 5'd0, 5'd3);
    ex_load = 1; ex_rt = 5'd0;
    tick();
    checks++;
    if (obs_vec !== exp_vec || obs_vec[CTRL_W+2] !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL zero_reg: got %h exp %h", obs_vec, exp_vec);
    end
    ex_load = 0; in_valid = 0;
  endtask

  task automatic test_exwrite();
    set_instr(6'h3f, 6'h02, 5'd1, 5'd2);
    tick();
    checks++;
    if (obs_vec !== exp_vec || out_ctrl[8] !== 1'b1) begin
      errors++; $display("FAIL exw_issue: got %h exp %h", obs_vec, exp_vec);
    end
    set_instr(6'h09, 6'h00, 5'd5, 5'd6);
    for (int i = 0; i < EXW_C + 1; i++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL exw_hold cyc%0d: got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_flush_exw();
    set_instr(6'h3f, 6'h01, 5'd1, 5'd2);
    tick();
    flush = 1;
    set_instr(6'h0f, 6'h00, 5'd0, 5'd7);
    tick();
    checks++;
    if (obs_vec !== exp_vec || obs_vec[CTRL_W+2] !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_exw: got %h exp %h", obs_vec, exp_vec);
    end
    flush = 0;
    tick();
    checks++;
    if (obs_vec !== exp_vec || obs_vec[CTRL_W+2] !== 1'b0) begin
      errors++; $display("FAIL flush_exw_after: got %h exp %h", obs_vec, exp_vec);
    end
    in_valid = 0;
  endtask

  task automatic test_hz_flush();
    set_instr(6'h00, 6'h22, 5'd10, 5'd11);
    ex_load = 1; ex_rt = 5'd11; flush = 1;
    tick();
    checks++;
    if (obs_vec !== exp_vec || obs_vec[CTRL_W+2] !== 1'b0) begin
      errors++; $display("FAIL hz_flush: got %h exp %h", obs_vec, exp_vec);
    end
    flush = 0; ex_load = 0;
    tick();
    checks++;
    if (obs_vec !== exp_vec || out_valid !== 1'b1) begin
      errors++; $display("FAIL hz_flush_next: got %h exp %h", obs_vec, exp_vec);
    end
    in_valid = 0;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  ops[3] = '{6'h03, 6'h00, 6'h0f};
    logic [5:0]  fns[3] = '{6'h00, 6'h08, 6'h00};
    logic [1:0]  pcs[3] = '{2'b10, 2'b11, 2'b00};
    logic [1:0]  m2r[3] = '{2'b10, 2'b00, 2'b00};
    logic        lus[3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      set_instr(ops[i], fns[i], 5'd12, 5'd13);
      tick();
      checks++;
      if (obs_vec !== exp_vec || out_ctrl[17:16] !== pcs[i] || out_ctrl[5:4] !== m2r[i] ||
          out_ctrl[0] !== lus[i]) begin
        errors++; $display("FAIL b2b op%h: got %h exp %h", ops[i], obs_vec, exp_vec);
      end
    end
    in_valid = 0;
  endtask

  task automatic test_illegal();
    set_instr(6'h3e, 6'h00, 5'd1, 5'd1);
    tick();
    checks++;
    if (obs_vec !== exp_vec || (TRAP && (obs_ill !== 1'b1 || out_valid !== 1'b0))) begin
      errors++; $display("FAIL illegal_op: got %h exp %h", obs_vec, exp_vec);
    end
    set_instr(6'h00, 6'h3a, 5'd1, 5'd1);
    tick();
    in_valid = 0;
    tick();
    checks++;
    if (obs_vec !== exp_vec || obs_ill !== 1'b0) begin
      errors++; $display("FAIL illegal_clear: got %h exp %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    logic [5:0] op_tab[20] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                               6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f, 6'h20, 6'h23, 6'h2b,
                               6'h3f, 6'h3e};
    int errs_before = errors;
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      flush    = ($urandom_range(0, 99) < 10);
      in_valid = ($urandom_range(0, 99) < 85);
      opcode   = op_tab[$urandom_range(0, 19)];
      funct    = 6'($urandom);
      rs       = 5'($urandom_range(0, 3));
      rt       = 5'($urandom_range(0, 3));
      ex_load  = ($urandom_range(0, 99) < 40);
      ex_rt    = 5'($urandom_range(0, 3));
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        if (errors - errs_before < 10)
          $display("FAIL random cyc%0d: got %h exp %h", i, obs_vec, exp_vec);
      end
    end
    reset = 0; flush = 0; in_valid = 0; ex_load = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; opcode = '0; funct = '0; rs = '0; rt = '0;
    ex_load = 0; ex_rt = '0; flush = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_exwrite();
    test_flush_exw();
    test_hz_flush();
    test_back_to_back();
    test_illegal();
    test_random();
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
